midi_receiver: RTL and testbench

MIDI_RECEIVER -- requirements
Module: midi_receiver

---
 rtl/midi_receiver.sv | 186 ++++++++++++++++++
 tb/tb_midi_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_receiver.sv
// MIDI UART receiver and note-on parser: 2-flop synchronizer, 8N1 UART, running-status parser.
// Define MIDI_CHANNEL_FILTER_EN to accept note-on only on channel CHANNEL.
module midi_receiver #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int BAUD    = 31250,
   parameter int CHANNEL = 0
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   input  logic       midi_rx_in,
   output logic       midi_valid,
   output logic [6:0] midi_key,
   output logic [6:0] midi_velocity,
   output logic       framing_error
);

   localparam int BitPeriod  = CLK_HZ / BAUD;
   localparam int HalfPeriod = BitPeriod / 2;
   localparam int CntW       = ($clog2(BitPeriod) > 0) ? $clog2(BitPeriod) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(BitPeriod - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(HalfPeriod - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_e;
   typedef enum logic [1:0] {NO_RUN, KEY, VEL} parseState_e;

   logic            sync1_q, sync2_q;
   logic            rxSync;
   uartState_e      uartState_q, uartState_d;
   logic [CntW-1:0] bitCnt_q, bitCnt_d;
   logic [2:0]      bitIdx_q, bitIdx_d;
   logic [7:0]      shift_q, shift_d;
   logic            errWait_q, errWait_d;
   logic            framingErr_q, framingErr_d;
   logic            byteValid;

   parseState_e     parseState_q, parseState_d;
   logic            runStatus_q, runStatus_d;
   logic [6:0]      keyPend_q, keyPend_d;
   logic [6:0]      midiKey_q, midiKey_d;
   logic [6:0]      midiVel_q, midiVel_d;
   logic            midiValid_q, midiValid_d;
   logic            isNoteOn;

   assign rxSync = sync2_q;

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         uartState_q  <= IDLE;
         bitCnt_q     <= '0;
         bitIdx_q     <= '0;
         shift_q      <= '0;
         errWait_q    <= 1'b0;
         framingErr_q <= 1'b0;
         parseState_q <= NO_RUN;
         runStatus_q  <= 1'b0;
         keyPend_q    <= '0;
         midiKey_q    <= '0;
         midiVel_q    <= '0;
         midiValid_q  <= 1'b0;
      end else begin
         sync1_q      <= midi_rx_in;
         sync2_q      <= sync1_q;
         uartState_q  <= uartState_d;
         bitCnt_q     <= bitCnt_d;
         bitIdx_q     <= bitIdx_d;
         shift_q      <= shift_d;
         errWait_q    <= errWait_d;
         framingErr_q <= framingErr_d;
         parseState_q <= parseState_d;
         runStatus_q  <= runStatus_d;
         keyPend_q    <= keyPend_d;
         midiKey_q    <= midiKey_d;
         midiVel_q    <= midiVel_d;
         midiValid_q  <= midiValid_d;
      end
   end

   // After a low stop bit the FSM parks in STOP until the line returns high,
   // so a held break is never mistaken for a new start bit.
   always_comb begin
      uartState_d  = uartState_q;
      bitCnt_d     = bitCnt_q;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      errWait_d    = errWait_q;
      framingErr_d = 1'b0;
      byteValid    = 1'b0;
      case (uartState_q)
         IDLE: begin
            bitCnt_d = '0;
            bitIdx_d = '0;
            if (!rxSync) uartState_d = START;
         end
         START: begin
            if (bitCnt_q == HalfCnt) begin
               bitCnt_d    = '0;
               uartState_d = rxSync ? IDLE : DATA;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bitCnt_q == LastCnt) begin
               bitCnt_d = '0;
               shift_d  = {rxSync, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) uartState_d = STOP;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         STOP: begin
            if (errWait_q) begin
               if (rxSync) begin
                  errWait_d   = 1'b0;
                  uartState_d = IDLE;
               end
            end else if (bitCnt_q == LastCnt) begin
               bitCnt_d = '0;
               if (rxSync) begin
                  byteValid   = 1'b1;
                  uartState_d = IDLE;
               end else begin
                  framingErr_d = 1'b1;
                  errWait_d    = 1'b1;
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         default: uartState_d = IDLE;
      endcase
   end

`ifdef MIDI_CHANNEL_FILTER_EN
   assign isNoteOn = (shift_q[7:4] == 4'h9) && (shift_q[3:0] == CHANNEL[3:0]);
`else
   logic unusedChannel;
   assign unusedChannel = ^CHANNEL;
   assign isNoteOn      = (shift_q[7:4] == 4'h9);
`endif

   // Realtime bytes fall through untouched; a data byte in VEL both completes
   // an event and re-arms KEY so running status keeps working.
   always_comb begin
      parseState_d = parseState_q;
      runStatus_d  = runStatus_q;
      keyPend_d    = keyPend_q;
      midiKey_d    = midiKey_q;
      midiVel_d    = midiVel_q;
      midiValid_d  = 1'b0;
      if (byteValid && (shift_q < 8'hF8)) begin
         if (shift_q >= 8'hF0) begin
            parseState_d = NO_RUN;
            runStatus_d  = 1'b0;
         end else if (shift_q[7]) begin
            parseState_d = isNoteOn ? KEY : NO_RUN;
            runStatus_d  = isNoteOn;
         end else begin
            case (parseState_q)
               KEY: begin
                  keyPend_d    = shift_q[6:0];
                  parseState_d = VEL;
               end
               VEL: begin
                  parseState_d = runStatus_q ? KEY : NO_RUN;
                  if (shift_q[6:0] != 7'd0) begin
                     midiKey_d   = keyPend_q;
                     midiVel_d   = shift_q[6:0];
                     midiValid_d = 1'b1;
                  end
               end
               default: parseState_d = NO_RUN;
            endcase
         end
      end
   end

   assign midi_valid    = midiValid_q;
   assign midi_key      = midiKey_q;
   assign midi_velocity = midiVel_q;
   assign framing_error = framingErr_q;

endmodule

// File: tb/tb_midi_receiver.sv
// Self-checking bench for midi_receiver: directed vector table, corner-case
// sequences and a randomized byte stream checked against a note-on event model.
module tb_midi_receiver;

   localparam int ClkHz = 1_000_000;
   localparam int Baud  = 31250;
   localparam int Bit   = ClkHz / Baud;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       rxLine = 1'b1;
   logic       midiValid, framingError;
   logic [6:0] midiKey, midiVelocity;

   midi_receiver #(.CLK_HZ(ClkHz), .BAUD(Baud), .CHANNEL(0)) dut (
      .clk_100MHz    (clock),
      .rst           (rst),
      .midi_rx_in    (rxLine),
      .midi_valid    (midiValid),
      .midi_key      (midiKey),
      .midi_velocity (midiVelocity),
      .framing_error (framingError)
   );

   always #5 clock = ~clock;

   typedef struct {
      int key;
      int vel;
      int cyc;
   } event_t;

   typedef struct {
      logic [39:0] bytes;
      int          n;
      int          pulses;
      int          k1, v1, k2, v2;
      bit          timed;
   } vec_t;

   event_t seen[$];
   event_t expected[$];
   vec_t   vecs[$];
   int     checkCount = 0;
   int     failCount = 0;
   int     cyc = 0;
   int     frameCount = 0;
   int     consecViol = 0;
   int     holdViol = 0;
   int     lastStartCyc = 0;
   logic       prevValid = 1'b0;
   logic       prevRst = 1'b1;
   logic [6:0] prevKey = '0, prevVel = '0;

   always @(posedge clock) cyc <= cyc + 1;

   // Observe outputs on the falling edge, away from the DUT's active edge.
   always @(negedge clock) begin
      if (midiValid) seen.push_back('{int'(midiKey), int'(midiVelocity), cyc});
      if (midiValid && prevValid) consecViol++;
      if (!rst && !prevRst && !midiValid && (midiKey !== prevKey || midiVelocity !== prevVel))
         holdViol++;
      if (framingError) frameCount++;
      prevValid = midiValid;
      prevRst   = rst;
      prevKey   = midiKey;
      prevVel   = midiVelocity;
   end

   task automatic checkOutput(input string name, input int actual, input int required);
      checkCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      rxLine = 1'b0;
      lastStartCyc = cyc;
      waitCycles(Bit);
      for (int i = 0; i < 8; i++) begin
         rxLine = b[i];
         waitCycles(Bit);
      end
      rxLine = stopBit;
      waitCycles(Bit);
      rxLine = 1'b1;
      waitCycles(4);
   endtask

   function automatic vec_t mk(input logic [39:0] b, input int n, input int p,
                               input int k1, input int v1, input int k2, input int v2,
                               input bit timed);
      vec_t v;
      v.bytes = b; v.n = n; v.pulses = p;
      v.k1 = k1; v.v1 = v1; v.k2 = k2; v.v2 = v2; v.timed = timed;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v, input string name);
      int base;
      base = seen.size();
      for (int j = 0; j < v.n; j++) sendByte(v.bytes[39-8*j -: 8], 1'b1);
      waitCycles(2 * Bit);
      checkOutput({name, " pulses"}, seen.size() - base, v.pulses);
      if (v.pulses >= 1 && seen.size() > base) begin
         checkOutput({name, " key1"}, seen[base].key, v.k1);
         checkOutput({name, " vel1"}, seen[base].vel, v.v1);
      end
      if (v.pulses >= 2 && seen.size() > base + 1) begin
         checkOutput({name, " key2"}, seen[base+1].key, v.k2);
         checkOutput({name, " vel2"}, seen[base+1].vel, v.v2);
      end
      if (v.timed && seen.size() > base) begin
         // Pulse lands one clock after the mid-stop-bit sample, plus sync latency.
         checkOutput({name, " latency ok"},
                     int'(seen[base].cyc >= lastStartCyc + 9*Bit + Bit/2 &&
                          seen[base].cyc <= lastStartCyc + 9*Bit + Bit/2 + 4), 1);
      end
      checkOutput({name, " key out"}, int'(midiKey), v.k2);
      checkOutput({name, " vel out"}, int'(midiVelocity), v.v2);
   endtask

   function automatic bit chanOk(input logic [7:0] b);
`ifdef MIDI_CHANNEL_FILTER_EN
      return b[3:0] == 4'd0;
`else
      return 1'b1;
`endif
   endfunction

   // Reference: a note-on status opens a (key, velocity) pair stream; any
   // other status or system-common byte closes it; realtime is invisible.
   task automatic modelStream(input logic [7:0] stream[$]);
      bit noteOn = 0, haveKey = 0;
      int pend = 0;
      foreach (stream[i]) begin
         if (stream[i] >= 8'hF8) continue;
         if (stream[i] >= 8'hF0) begin
            noteOn = 0; haveKey = 0;
         end else if (stream[i] >= 8'h80) begin
            noteOn = (stream[i][7:4] == 4'h9) && chanOk(stream[i]);
            haveKey = 0;
         end else if (noteOn) begin
            if (!haveKey) begin
               pend = int'(stream[i]); haveKey = 1;
            end else begin
               haveKey = 0;
               if (stream[i] != 0) expected.push_back('{pend, int'(stream[i]), 0});
            end
         end
      end
   endtask

   initial begin
      int base, fbase;
      logic [7:0] stream[$];
      logic [7:0] b;

      vecs.push_back(mk({8'h90, 8'h24, 8'h64, 16'h0}, 3, 1, 36, 100, 36, 100, 1));
      vecs.push_back(mk({8'h99, 8'h26, 8'h40, 8'h2E, 8'h7F}, 5, 2, 38, 64, 46, 127, 0));
      vecs.push_back(mk({8'h90, 8'h24, 8'hF8, 8'h50, 8'h0}, 4, 1, 36, 80, 36, 80, 0));
      vecs.push_back(mk({8'h90, 8'h24, 8'h00, 16'h0}, 3, 0, 0, 0, 36, 80, 0));
      vecs.push_back(mk({8'h80, 8'h24, 8'h40, 16'h0}, 3, 0, 0, 0, 36, 80, 0));
`ifdef MIDI_CHANNEL_FILTER_EN
      vecs.push_back(mk({8'h91, 8'h24, 8'h64, 16'h0}, 3, 0, 0, 0, 36, 80, 0));
      vecs.push_back(mk({8'hF0, 8'h24, 8'h64, 16'h0}, 3, 0, 0, 0, 36, 80, 0));
      vecs.push_back(mk({8'h90, 8'h3C, 8'h7F, 8'h40, 8'h00}, 5, 1, 60, 127, 60, 127, 0));
`else
      vecs.push_back(mk({8'h91, 8'h24, 8'h64, 16'h0}, 3, 1, 36, 100, 36, 100, 0));
      vecs.push_back(mk({8'hF0, 8'h24, 8'h64, 16'h0}, 3, 0, 0, 0, 36, 100, 0));
      vecs.push_back(mk({8'h90, 8'h3C, 8'h7F, 8'h40, 8'h00}, 5, 1, 60, 127, 60, 127, 0));
`endif

      waitCycles(3);
      checkOutput("reset valid", int'(midiValid), 0);
      checkOutput("reset key", int'(midiKey), 0);
      checkOutput("reset vel", int'(midiVelocity), 0);
      checkOutput("reset ferr", int'(framingError), 0);
      rst = 1'b0;
      waitCycles(5);

      foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      fbase = frameCount;
      base  = seen.size();
      sendByte(8'h55, 1'b0);
      waitCycles(2 * Bit);
      checkOutput("ferr count", frameCount - fbase, 1);
      checkOutput("ferr no event", seen.size() - base, 0);

      // Short low glitch, scaled to the same fraction of a bit as 1000 of 3200 cycles.
      rxLine = 1'b0;
      waitCycles(10);
      rxLine = 1'b1;
      waitCycles(3 * Bit);
      checkOutput("glitch ferr", frameCount - fbase, 1);
      checkOutput("glitch no event", seen.size() - base, 0);
      applyStimulus(mk({8'h90, 8'h24, 8'h64, 16'h0}, 3, 1, 36, 100, 36, 100, 0), "post glitch");

      rxLine = 1'b0;
      waitCycles(Bit);
      rxLine = 1'b1;
      waitCycles(2 * Bit + Bit / 2);
      rst = 1'b1;
      waitCycles(2);
      checkOutput("mid rst valid", int'(midiValid), 0);
      checkOutput("mid rst key", int'(midiKey), 0);
      checkOutput("mid rst vel", int'(midiVelocity), 0);
      checkOutput("mid rst ferr", int'(framingError), 0);
      waitCycles(3);
      rst = 1'b0;
      waitCycles(2 * Bit);
      applyStimulus(mk({8'h90, 8'h24, 8'h64, 16'h0}, 3, 1, 36, 100, 36, 100, 0), "post rst");

      stream.push_back(8'hF0);
      for (int i = 0; i < 45; i++) begin
         case ($urandom_range(0, 11))
            0, 1, 2: b = 8'h90 | 8'($urandom_range(0, 15));
            3:       b = 8'h80 + 8'($urandom_range(0, 111));
            4:       b = 8'hF8 + 8'($urandom_range(0, 7));
            5:       b = 8'hF0 + 8'($urandom_range(0, 7));
            6:       b = 8'h00;
            default: b = 8'($urandom_range(1, 127));
         endcase
         stream.push_back(b);
      end
      modelStream(stream);
      base = seen.size();
      foreach (stream[i]) sendByte(stream[i], 1'b1);
      waitCycles(2 * Bit);
      checkOutput("rand event count", seen.size() - base, expected.size());
      foreach (expected[i]) begin
         if (base + i < seen.size()) begin
            checkOutput($sformatf("rand key%0d", i), seen[base+i].key, expected[i].key);
            checkOutput($sformatf("rand vel%0d", i), seen[base+i].vel, expected[i].vel);
         end
      end

      checkOutput("no back-to-back valid", consecViol, 0);
      checkOutput("outputs held between events", holdViol, 0);
      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end

endmodule
